// File: rtl/felis_mem_pkg.sv
// Shared types for the memory-port arbiter: FSM states, client index and
// the latched request bundle.
package felis_mem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef logic client_id_t;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } client_req_t;

    function automatic client_req_t pick_req(input client_id_t  idx,
                                             input client_req_t r0,
                                             input client_req_t r1);
        return idx ? r1 : r0;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way grant: round-robin on contention when FAIR=1,
// otherwise client 1 has fixed priority.
module rr_arbiter2
    import felis_mem_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic [1:0] req_i,
    input  client_id_t last_grant_i,
    output logic       gnt_valid_o,
    output client_id_t gnt_idx_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = 1'b0;
        if (req_i == 2'b11) begin
            gnt_idx_o = FAIR ? ~last_grant_i : 1'b1;
        end else begin
            gnt_idx_o = req_i[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store word requests onto the
// single-port memory's write and read handshakes.
module mem_port_arbiter
    import felis_mem_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_req,
    input  logic              c1_req,
    input  logic              c0_we,
    input  logic              c1_we,
    input  logic [WORD_W-1:0] c0_addr,
    input  logic [WORD_W-1:0] c1_addr,
    input  logic [WORD_W-1:0] c0_wdata,
    input  logic [WORD_W-1:0] c1_wdata,
    output logic              c0_done,
    output logic              c1_done,
    output logic [WORD_W-1:0] c0_rdata,
    output logic [WORD_W-1:0] c1_rdata,
    output logic              mem_in_valid,
    output logic [WORD_W-1:0] mem_in_addr,
    output logic [WORD_W-1:0] mem_in_data,
    input  logic              mem_in_ready,
    output logic              mem_out_valid,
    output logic [WORD_W-1:0] mem_out_addr,
    input  logic [WORD_W-1:0] mem_out_data,
    input  logic              mem_out_ready,
    input  logic              mem_addr_error,
    output logic              err,
    output logic              err_client
);

    arb_state_t        state_q;
    client_id_t        last_grant_q;
    client_id_t        grant_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              mem_in_valid_q;
    logic              mem_out_valid_q;
    logic              c0_done_q;
    logic              c1_done_q;
    logic [WORD_W-1:0] c0_rdata_q;
    logic [WORD_W-1:0] c1_rdata_q;
    logic              err_q;
    logic              err_client_q;

    logic              gnt_valid;
    client_id_t        gnt_idx;
    client_req_t       req0;
    client_req_t       req1;
    client_req_t       sel_req;

    always_comb begin
        req0.we    = c0_we;
        req0.addr  = c0_addr;
        req0.wdata = c0_wdata;
        req1.we    = c1_we;
        req1.addr  = c1_addr;
        req1.wdata = c1_wdata;
        sel_req    = pick_req(gnt_idx, req0, req1);
    end

    rr_arbiter2 #(
        .FAIR(FAIR)
    ) u_arb (
        .req_i       ({c1_req, c0_req}),
        .last_grant_i(last_grant_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            last_grant_q    <= 1'b1;
            grant_q         <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            mem_in_valid_q  <= 1'b0;
            mem_out_valid_q <= 1'b0;
            c0_done_q       <= 1'b0;
            c1_done_q       <= 1'b0;
            c0_rdata_q      <= '0;
            c1_rdata_q      <= '0;
            err_q           <= 1'b0;
            err_client_q    <= 1'b0;
        end else begin
            c0_done_q <= 1'b0;
            c1_done_q <= 1'b0;

            // Only the first sighting is captured; the memory's flag is sticky.
            if (mem_addr_error && !err_q) begin
                err_q        <= 1'b1;
                err_client_q <= grant_q;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        grant_q      <= gnt_idx;
                        last_grant_q <= gnt_idx;
                        addr_q       <= sel_req.addr;
                        wdata_q      <= sel_req.wdata;
                        if (sel_req.we) begin
                            mem_in_valid_q <= 1'b1;
                            state_q        <= ST_WRITE;
                        end else begin
                            mem_out_valid_q <= 1'b1;
                            state_q         <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_in_ready) begin
                        mem_in_valid_q <= 1'b0;
                        if (grant_q) c1_done_q <= 1'b1;
                        else         c0_done_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_READ: begin
                    if (mem_out_ready) begin
                        mem_out_valid_q <= 1'b0;
                        if (grant_q) begin
                            c1_rdata_q <= mem_out_data;
                            c1_done_q  <= 1'b1;
                        end else begin
                            c0_rdata_q <= mem_out_data;
                            c0_done_q  <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Idle gap lets the memory return to its inactive state.
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign c0_done       = c0_done_q;
    assign c1_done       = c1_done_q;
    assign c0_rdata      = c0_rdata_q;
    assign c1_rdata      = c1_rdata_q;
    assign mem_in_valid  = mem_in_valid_q;
    assign mem_in_addr   = addr_q;
    assign mem_in_data   = wdata_q;
    assign mem_out_valid = mem_out_valid_q;
    assign mem_out_addr  = addr_q;
    assign err           = err_q;
    assign err_client    = err_client_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a FAIR=1 and a FAIR=0 arbiter, each in front of a small
// memory model with fixed write (2-cycle) and read (4-cycle) handshakes.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;

    logic        c0_req[2], c1_req[2], c0_we[2], c1_we[2];
    logic [31:0] c0_addr[2], c1_addr[2], c0_wdata[2], c1_wdata[2];
    logic        c0_done[2], c1_done[2];
    logic [31:0] c0_rdata[2], c1_rdata[2];
    logic        mem_in_valid[2], mem_in_ready[2], mem_out_valid[2], mem_out_ready[2];
    logic        mem_addr_error[2], err[2], err_client[2];
    logic [31:0] mem_in_addr[2], mem_in_data[2], mem_out_addr[2], mem_out_data[2];

    logic [31:0] store[2][256];
    int          rcnt[2];
    int          overlap = 0;
    int          checks = 0;
    int          failures = 0;
    int          p, g;

    always #5 clk = ~clk;

    mem_port_arbiter #(.FAIR(1'b1)) u_fair (
        .clk(clk), .reset(reset),
        .c0_req(c0_req[0]), .c1_req(c1_req[0]), .c0_we(c0_we[0]), .c1_we(c1_we[0]),
        .c0_addr(c0_addr[0]), .c1_addr(c1_addr[0]), .c0_wdata(c0_wdata[0]), .c1_wdata(c1_wdata[0]),
        .c0_done(c0_done[0]), .c1_done(c1_done[0]), .c0_rdata(c0_rdata[0]), .c1_rdata(c1_rdata[0]),
        .mem_in_valid(mem_in_valid[0]), .mem_in_addr(mem_in_addr[0]), .mem_in_data(mem_in_data[0]),
        .mem_in_ready(mem_in_ready[0]), .mem_out_valid(mem_out_valid[0]), .mem_out_addr(mem_out_addr[0]),
        .mem_out_data(mem_out_data[0]), .mem_out_ready(mem_out_ready[0]),
        .mem_addr_error(mem_addr_error[0]), .err(err[0]), .err_client(err_client[0])
    );

    mem_port_arbiter #(.FAIR(1'b0)) u_fixed (
        .clk(clk), .reset(reset),
        .c0_req(c0_req[1]), .c1_req(c1_req[1]), .c0_we(c0_we[1]), .c1_we(c1_we[1]),
        .c0_addr(c0_addr[1]), .c1_addr(c1_addr[1]), .c0_wdata(c0_wdata[1]), .c1_wdata(c1_wdata[1]),
        .c0_done(c0_done[1]), .c1_done(c1_done[1]), .c0_rdata(c0_rdata[1]), .c1_rdata(c1_rdata[1]),
        .mem_in_valid(mem_in_valid[1]), .mem_in_addr(mem_in_addr[1]), .mem_in_data(mem_in_data[1]),
        .mem_in_ready(mem_in_ready[1]), .mem_out_valid(mem_out_valid[1]), .mem_out_addr(mem_out_addr[1]),
        .mem_out_data(mem_out_data[1]), .mem_out_ready(mem_out_ready[1]),
        .mem_addr_error(mem_addr_error[1]), .err(err[1]), .err_client(err_client[1])
    );

    // Memory model: write ready on the 2nd valid cycle, read ready on the 4th.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mem_in_ready[k]   <= 1'b0;
                mem_out_ready[k]  <= 1'b0;
                mem_out_data[k]   <= '0;
                mem_addr_error[k] <= 1'b0;
                rcnt[k]           <= 0;
                store[k][0]       <= 32'h1234_5678;
                store[k][1]       <= 32'hCAFE_F00D;
            end else begin
                if (mem_in_ready[k]) begin
                    mem_in_ready[k] <= 1'b0;
                    store[k][mem_in_addr[k][9:2]] <= mem_in_data[k];
                end else if (mem_in_valid[k]) begin
                    mem_in_ready[k] <= 1'b1;
                end
                if (mem_out_ready[k]) begin
                    mem_out_ready[k] <= 1'b0;
                    rcnt[k]          <= 0;
                end else if (mem_out_valid[k]) begin
                    if (rcnt[k] == 2) begin
                        mem_out_ready[k] <= 1'b1;
                        mem_out_data[k]  <= (mem_out_addr[k][31:2] >= 30'd655360) ? 32'h0
                                            : store[k][mem_out_addr[k][9:2]];
                    end else begin
                        rcnt[k] <= rcnt[k] + 1;
                    end
                end
                if ((mem_in_valid[k] || mem_out_valid[k]) && mem_out_addr[k][31:2] >= 30'd655360)
                    mem_addr_error[k] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            if (mem_in_valid[k] === 1'b1 && mem_out_valid[k] === 1'b1) overlap++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_dones"}, {30'd0, c1_done[i], c0_done[i]}, 32'd0);
        chk({tag, "_valids"}, {30'd0, mem_in_valid[i], mem_out_valid[i]}, 32'd0);
        chk({tag, "_c0_rdata"}, c0_rdata[i], 32'd0);
        chk({tag, "_c1_rdata"}, c1_rdata[i], 32'd0);
        chk({tag, "_in_addr"}, mem_in_addr[i], 32'd0);
        chk({tag, "_in_data"}, mem_in_data[i], 32'd0);
        chk({tag, "_out_addr"}, mem_out_addr[i], 32'd0);
        chk({tag, "_err"}, {30'd0, err[i], err_client[i]}, 32'd0);
    endtask

    // Caller is at the negedge of an IDLE cycle (cycle 0); returns at the
    // negedge of the cycle after DONE.
    task automatic run_txn(input int i, input bit cl, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rexp, input string tag);
        int nv;
        if (cl) begin
            c1_req[i] = 1'b1; c1_we[i] = we; c1_addr[i] = addr; c1_wdata[i] = wdata;
        end else begin
            c0_req[i] = 1'b1; c0_we[i] = we; c0_addr[i] = addr; c0_wdata[i] = wdata;
        end
        nv = we ? 2 : 4;
        for (int c = 1; c <= nv; c++) begin
            @(negedge clk);
            chk({tag, "_in_valid"}, {31'd0, mem_in_valid[i]}, {31'd0, we});
            chk({tag, "_out_valid"}, {31'd0, mem_out_valid[i]}, {31'd0, ~we});
            chk({tag, "_addr"}, we ? mem_in_addr[i] : mem_out_addr[i], addr);
            if (we) chk({tag, "_wdata"}, mem_in_data[i], wdata);
            chk({tag, "_no_done"}, {30'd0, c1_done[i], c0_done[i]}, 32'd0);
        end
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, c1_done[i], c0_done[i]}, cl ? 32'd2 : 32'd1);
        chk({tag, "_gap"}, {30'd0, mem_in_valid[i], mem_out_valid[i]}, 32'd0);
        if (!we) chk({tag, "_rdata"}, cl ? c1_rdata[i] : c0_rdata[i], rexp);
        if (cl) c1_req[i] = 1'b0; else c0_req[i] = 1'b0;
        @(negedge clk);
        chk({tag, "_done_low"}, {30'd0, c1_done[i], c0_done[i]}, 32'd0);
        if (!we) chk({tag, "_rdata_hold"}, cl ? c1_rdata[i] : c0_rdata[i], rexp);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            c0_req[i] = 1'b0; c1_req[i] = 1'b0; c0_we[i] = 1'b0; c1_we[i] = 1'b0;
            c0_addr[i] = '0; c1_addr[i] = '0; c0_wdata[i] = '0; c1_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_zero(0, "rst_fair");
        chk_zero(1, "rst_fixed");
        reset = 1'b0;
        @(negedge clk);

        // Contention, FAIR=1: reads alternate 0,1,0,1 with a 6-cycle period.
        c0_we[0] = 1'b0; c0_addr[0] = 32'h0;
        c1_we[0] = 1'b0; c1_addr[0] = 32'h4;
        c0_req[0] = 1'b1; c1_req[0] = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            @(negedge clk);
            p = (t == 25) ? 0 : t % 6;
            g = (t / 6) % 2;
            if (p == 0) begin
                chk("rr_idle_valids", {30'd0, mem_in_valid[0], mem_out_valid[0]}, 32'd0);
                chk("rr_idle_dones", {30'd0, c1_done[0], c0_done[0]}, 32'd0);
            end else if (p <= 4) begin
                chk("rr_out_valid", {31'd0, mem_out_valid[0]}, 32'd1);
                chk("rr_in_valid", {31'd0, mem_in_valid[0]}, 32'd0);
                chk("rr_addr", mem_out_addr[0], (g == 1) ? 32'h4 : 32'h0);
                chk("rr_no_done", {30'd0, c1_done[0], c0_done[0]}, 32'd0);
            end else begin
                chk("rr_done", {30'd0, c1_done[0], c0_done[0]}, (g == 1) ? 32'd2 : 32'd1);
                chk("rr_gap", {30'd0, mem_in_valid[0], mem_out_valid[0]}, 32'd0);
                chk("rr_rdata", (g == 1) ? c1_rdata[0] : c0_rdata[0],
                    (g == 1) ? 32'hCAFE_F00D : 32'h1234_5678);
            end
            if (t == 23) begin
                c0_req[0] = 1'b0; c1_req[0] = 1'b0;
            end
        end

        run_txn(0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, "wr_c1");
        run_txn(0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, "rd_back");
        run_txn(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_5678, "rd_c0");
        chk("err_before", {30'd0, err[0], err_client[0]}, 32'd0);

        run_txn(0, 1'b1, 1'b0, 32'h0028_0000, 32'h0, 32'h0, "err_rd");
        chk("err_set", {30'd0, err[0], err_client[0]}, 32'd3);
        run_txn(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_5678, "post_err");
        chk("err_sticky", {30'd0, err[0], err_client[0]}, 32'd3);

        // Reset lands on the edge ending cycle 2 of a read.
        c0_req[0] = 1'b1; c0_we[0] = 1'b0; c0_addr[0] = 32'h4;
        @(negedge clk);
        chk("mid_out_valid", {31'd0, mem_out_valid[0]}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        c0_req[0] = 1'b0;
        @(negedge clk);
        chk_zero(0, "mid_rst");
        reset = 1'b0;
        @(negedge clk);
        chk_zero(0, "after_rst");
        run_txn(0, 1'b0, 1'b0, 32'h4, 32'h0, 32'hCAFE_F00D, "reissue");

        // Fixed priority: client 1 write goes first, client 0 read follows.
        c1_req[1] = 1'b1; c1_we[1] = 1'b1; c1_addr[1] = 32'h8; c1_wdata[1] = 32'h55AA_55AA;
        c0_req[1] = 1'b1; c0_we[1] = 1'b0; c0_addr[1] = 32'h0;
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk);
            if (t <= 2) begin
                chk("fx_in_valid", {30'd0, mem_in_valid[1], mem_out_valid[1]}, 32'd2);
                chk("fx_in_addr", mem_in_addr[1], 32'h8);
            end else if (t == 3) begin
                chk("fx_c1_done", {30'd0, c1_done[1], c0_done[1]}, 32'd2);
                c1_req[1] = 1'b0;
            end else if (t == 4) begin
                chk("fx_gap", {30'd0, mem_in_valid[1], mem_out_valid[1]}, 32'd0);
                chk("fx_gap_done", {30'd0, c1_done[1], c0_done[1]}, 32'd0);
            end else if (t <= 8) begin
                chk("fx_out_valid", {30'd0, mem_in_valid[1], mem_out_valid[1]}, 32'd1);
                chk("fx_out_addr", mem_out_addr[1], 32'h0);
            end else begin
                chk("fx_c0_done", {30'd0, c1_done[1], c0_done[1]}, 32'd1);
                chk("fx_c0_rdata", c0_rdata[1], 32'h1234_5678);
                c0_req[1] = 1'b0;
            end
        end
        @(negedge clk);
        run_txn(1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h55AA_55AA, "fx_rb");

        chk("no_overlap", overlap, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-client arbiter in front of the single-port large memory. It accepts word requests from instruction fetch (client 0) and data load/store (client 1) and serialises them onto the memory's write (`in_*`) and read (`out_*`) handshakes. It returns read data and a one-cycle completion pulse to the granted client, and forwards address errors tagged with the offending client.

## Interface
- `FAIR`, default 1: 1 selects round-robin on contention; 0 gives client 1 fixed priority.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `c0_req`, `c1_req`  in  1  request; fields must be held stable until `done`.
- `c0_we`, `c1_we`  in  1  1 = write, 0 = read.
- `c0_addr`, `c1_addr`  in  32  byte address, word-aligned.
- `c0_wdata`, `c1_wdata`  in  32  write data.
- `c0_done`, `c1_done`  out  1  one-cycle completion pulse.
- `c0_rdata`, `c1_rdata`  out  32  read data; valid while `done` is high, held afterwards.
- `mem_in_valid`  out  1  write request to memory.
- `mem_in_addr`, `mem_in_data`  out  32  write address and data.
- `mem_in_ready`  in  1  write accepted.
- `mem_out_valid`  out  1  read request to memory.
- `mem_out_addr`  out  32  read address.
- `mem_out_data`  in  32  read data.
- `mem_out_ready`  in  1  read data valid.
- `mem_addr_error`  in  1  sticky error from memory.
- `err`  out  1  sticky; set on the first cycle `mem_addr_error` is seen high.
- `err_client`  out  1  client granted when `err` was set.

## Operation
- **States:** IDLE, WRITE, READ, DONE.
- **IDLE:**
  - Sample `c0_req` and `c1_req`.
  - Single requester: grant it.
  - Both requesting, `FAIR`=1: grant the client not granted last. `last_grant` resets to 1, so client 0 wins the first contention.
  - Both requesting, `FAIR`=0: grant client 1.
  - On grant: latch `we`, `addr`, `wdata` and the grant index. Go to WRITE (asserting `mem_in_valid`) or READ (asserting `mem_out_valid`).
  - Drive `mem_in_addr` and `mem_out_addr` from the latched address in both cases.
- **WRITE:**
  - Hold `mem_in_valid`=1 until `mem_in_ready`=1 is sampled.
  - At that edge: clear `mem_in_valid`, pulse the granted `done`, go to DONE.
- **READ:**
  - Hold `mem_out_valid`=1 until `mem_out_ready`=1 is sampled.
  - At that edge: clear `mem_out_valid`, register `mem_out_data` into the granted `rdata`, pulse `done`, go to DONE.
- **DONE:**
  - Both memory valids are low for this cycle. This gives the memory its required idle gap so its internal state returns to inactive.
  - Go to IDLE.
- **Request hold:** a client must drop `req` in the cycle after `done`. If `req` is still high in IDLE, it is a new request.
- **Exclusivity:** `mem_in_valid` and `mem_out_valid` are never high together.
- **Ungranted clients:** their `req` is ignored until IDLE.
- **Errors:** `err` and `err_client` clear only on reset.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last_grant`=1.
- **Reset mid-transaction:** the transaction is abandoned, no `done` is pulsed, and the client must reissue.
- Cycle 0 is the IDLE cycle in which `req` is sampled.
- **Write:** `mem_in_valid` high in cycles 1–2; `mem_in_ready` seen in cycle 2; `done` in cycle 3. Next grant no earlier than cycle 4.
- **Read:** `mem_out_valid` high in cycles 1–4; `mem_out_ready` seen in cycle 4; `done` and `rdata` in cycle 5. Next grant no earlier than cycle 6.
- **Latency scaling:** latency scales with any extra memory wait cycles. There is no timeout.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Package `felis_mem_pkg`:**
  - state enum `arb_state_t`
  - `client_id_t` (1 bit)
  - `WORD_W` = 32
- **Sub-module `rr_arbiter2`:**
  - Combinational two-way grant from `req[1:0]`, `last_grant` and `FAIR`.
  - `last_grant` register lives in the parent and updates on each grant.

## Test plan
- **Single write:** `c1_req`, `we`=1, `addr`=0x100, `wdata`=0xDEADBEEF → `mem_in_valid` cycles 1–2 with `addr` 0x100; `c1_done` in cycle 3; a later c0 read of 0x100 returns 0xDEADBEEF.
- **Single read:** c0 read of 0x0 after preload 0x12345678 → `mem_out_valid` cycles 1–4; `c0_done` and `c0_rdata`=0x12345678 in cycle 5; `c1_done` stays 0.
- **Contention:** both clients hold read requests continuously, `FAIR`=1 → grants alternate 0,1,0,1; DONE gap observed each time; `mem_in_valid` and `mem_out_valid` never high together.
- **Fixed priority:** `FAIR`=0, both requesting → client 1 is served first; client 0 is served after client 1 drops `req`.
- **Address error:** c1 read of 0x00280000 (word 655360) → `err`=1 and `err_client`=1 persist through later good transactions until reset.
- **Reset mid-read:** `reset` asserted in cycle 2 of a read → no `done`; all outputs 0 next cycle; a reissued read completes normally.
